// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mul_arb_pkg;

  localparam int OPW = 32;
  localparam int RW  = 64;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DELIVER
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the requester at ptr has top priority,
// then ptr+1, ptr+2, ... with wrap-around.
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_any
);

  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the closest-to-ptr requester wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one iterative multiplier between NUM_REQ requesters with round-robin
// grants, start/done sequencing, response handshake and a completion watchdog.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OPW-1:0]   req_a,
  input  logic [NUM_REQ*OPW-1:0]   req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [RW-1:0]            rsp_r,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic                     mul_valid_in,
  output logic [OPW-1:0]           mul_a,
  output logic [OPW-1:0]           mul_b,
  input  logic                     mul_valid_out,
  input  logic [RW-1:0]            mul_r
);

  localparam int CW = clog2(TIMEOUT_CYCLES) + 1;

  state_t              state_reg;
  logic [IDW-1:0]      rr_ptr_reg;
  logic [CW-1:0]       wait_cnt_reg;

  logic [OPW-1:0]      a_arr [NUM_REQ];
  logic [OPW-1:0]      b_arr [NUM_REQ];

  logic [NUM_REQ-1:0]  win_oh;
  logic [IDW-1:0]      win_idx;
  logic                win_any;
  logic                accept;
  logic [IDW-1:0]      rr_ptr_next;
  logic [NUM_REQ-1:0]  owner_oh;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[OPW*gi +: OPW];
      assign b_arr[gi] = req_b[OPW*gi +: OPW];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .grant_any (win_any)
  );

  // Gate with reset_n so no requester sees an accept while reset is asserted.
  assign accept      = reset_n && (state_reg == IDLE) && win_any;
  assign req_ready   = accept ? win_oh : '0;
  assign busy        = (state_reg != IDLE);
  assign rr_ptr_next = IDW'((int'(grant_id) + 1) % NUM_REQ);
  assign owner_oh    = NUM_REQ'(1) << grant_id;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      wait_cnt_reg <= '0;
      grant_id     <= '0;
      mul_valid_in <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      rsp_valid    <= '0;
      rsp_r        <= '0;
      rsp_err      <= 1'b0;
    end else begin
      mul_valid_in <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_any) begin
            mul_a        <= a_arr[win_idx];
            mul_b        <= b_arr[win_idx];
            grant_id     <= win_idx;
            mul_valid_in <= 1'b1;
            state_reg    <= LAUNCH;
          end
        end
        LAUNCH: begin
          // mul_valid_out may still be high from the previous op here; not looked at.
          wait_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (mul_valid_out) begin
            rsp_r     <= mul_r;
            rsp_err   <= 1'b0;
            rsp_valid <= owner_oh;
            state_reg <= DELIVER;
          end else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_r     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= owner_oh;
            state_reg <= DELIVER;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        DELIVER: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid  <= '0;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural iterative multiplier model.
module tb_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int TMO     = 64;
  localparam int LAT     = 3;
  localparam int NLAT    = LAT + 2;
  localparam int TLAT    = TMO + 1;

  logic                   clk;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*32-1:0]  req_a;
  logic [NUM_REQ*32-1:0]  req_b;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [63:0]            rsp_r;
  logic                   rsp_err;
  logic                   busy;
  logic [IDW-1:0]         grant_id;
  logic                   mul_valid_in;
  logic [31:0]            mul_a;
  logic [31:0]            mul_b;
  logic                   mul_valid_out;
  logic [63:0]            mul_r;

  int n_checks = 0;
  int n_errors = 0;

  mul_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .IDW            (IDW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_r         (rsp_r),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .grant_id      (grant_id),
    .mul_valid_in  (mul_valid_in),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_valid_out (mul_valid_out),
    .mul_r         (mul_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: result LAT edges after the start pulse, level held until next start.
  logic        hang = 1'b0;
  logic        pend = 1'b0;
  int          mcnt = 0;
  logic [31:0] la = '0;
  logic [31:0] lb = '0;
  initial begin
    mul_valid_out = 1'b0;
    mul_r         = '0;
  end
  always @(posedge clk) begin
    if (mul_valid_in) begin
      pend          <= 1'b1;
      mcnt          <= LAT - 1;
      mul_valid_out <= 1'b0;
      la            <= mul_a;
      lb            <= mul_b;
    end else if (pend) begin
      if (mcnt == 0) begin
        pend <= 1'b0;
        if (!hang) begin
          mul_valid_out <= 1'b1;
          mul_r         <= {32'b0, la} * {32'b0, lb};
        end
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_rsp_r", rsp_r, 64'(0));
    chk("rst_mul_valid_in", 64'(mul_valid_in), 64'(0));
    chk("rst_mul_a", 64'(mul_a), 64'(0));
    chk("rst_mul_b", 64'(mul_b), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
  endtask

  // One full transaction for requester id: accept, launch, wait, deliver, handshake.
  task automatic serve(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_r, input logic exp_err,
                       input int exp_lat, input int hold);
    int n;
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (req_ready == '0 && n < 200) begin
      step();
      #1;
      n++;
    end
    chk("req_ready", 64'(req_ready), 64'(oh));
    step();
    req_valid[id] = 1'b0;
    #1;
    chk("launch_pulse", 64'(mul_valid_in), 64'(1));
    chk("launch_a", 64'(mul_a), 64'(a));
    chk("launch_b", 64'(mul_b), 64'(b));
    chk("grant_id", 64'(grant_id), 64'(id));
    chk("launch_no_ready", 64'(req_ready), 64'(0));
    step();
    #1;
    n = 1;
    chk("pulse_single", 64'(mul_valid_in), 64'(0));
    while (rsp_valid == '0 && n < 300) begin
      step();
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("rsp_r", rsp_r, exp_r);
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    rsp_ready = ~oh;
    for (int c = 0; c < hold; c++) begin
      step();
      #1;
      chk("hold_r", rsp_r, exp_r);
      chk("hold_valid", 64'(rsp_valid), 64'(oh));
      chk("hold_no_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = oh;
    step();
    rsp_ready = '0;
    #1;
    chk("rsp_drop", 64'(rsp_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          rid;

    tbl[0] = '{1, 32'd7, 32'd9, 64'd63};
    tbl[1] = '{2, 32'd12345, 32'd678, 64'd8369910};
    tbl[2] = '{0, 32'd0, 32'hFFFFFFFF, 64'd0};
    tbl[3] = '{3, 32'h80000000, 32'd2, 64'h1_0000_0000};

    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    step();
    step();
    #1;
    reset_checks();
    reset_n = 1'b1;

    // Single requests from the table
    for (int i = 0; i < 4; i++) begin
      serve(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].r, 1'b0, NLAT, 0);
    end

    // Round-robin pointer: after 2 is served, 3 beats 0
    serve(2, 32'd10, 32'd10, 64'd100, 1'b0, NLAT, 0);
    req_a[0 +: 32] = 32'd5;  req_b[0 +: 32] = 32'd5;  req_valid[0] = 1'b1;
    req_a[96 +: 32] = 32'd6; req_b[96 +: 32] = 32'd7; req_valid[3] = 1'b1;
    serve(3, 32'd6, 32'd7, 64'd42, 1'b0, NLAT, 0);
    serve(0, 32'd5, 32'd5, 64'd25, 1'b0, NLAT, 0);

    // Contention from reset: all four valid while reset asserted
    reset_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = 32'(i + 1);
      req_b[32*i +: 32] = 32'd1000;
    end
    req_valid = '1;
    step();
    #1;
    reset_checks();
    reset_n = 1'b1;
    for (int round = 0; round < 2; round++) begin
      req_valid = '1;
      for (int i = 0; i < NUM_REQ; i++) begin
        serve(i, 32'(i + 1), 32'd1000, 64'((i + 1) * 1000), 1'b0, NLAT, 0);
      end
    end

    // Back-pressure with all-ones operands while requester 2 waits
    req_a[64 +: 32] = 32'd3; req_b[64 +: 32] = 32'd3; req_valid[2] = 1'b1;
    serve(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, NLAT, 10);
    serve(2, 32'd3, 32'd3, 64'd9, 1'b0, NLAT, 0);

    // Random operand pairs
    for (int k = 0; k < 100; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      rid = $urandom_range(0, NUM_REQ - 1);
      serve(rid, ra, rb, {32'b0, ra} * {32'b0, rb}, 1'b0, NLAT, 0);
    end

    // Timeout with a stale mul_valid_out level left from the previous op
    chk("stale_level_pre", 64'(mul_valid_out), 64'(1));
    hang = 1'b1;
    serve(2, 32'd5, 32'd6, 64'd0, 1'b1, TLAT, 0);
    hang = 1'b0;

    // Reset during WAIT, late result must be ignored
    req_a[0 +: 32] = 32'd3; req_b[0 +: 32] = 32'd4; req_valid[0] = 1'b1;
    #1;
    for (int c = 0; c < 50 && req_ready == '0; c++) begin
      step();
      #1;
    end
    step();
    req_valid[0] = 1'b0;
    step();
    #1;
    chk("mid_busy_pre", 64'(busy), 64'(1));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_mul_a", 64'(mul_a), 64'(0));
    for (int c = 0; c < 8; c++) begin
      step();
      #1;
      chk("late_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("late_busy", 64'(busy), 64'(0));
    end
    serve(1, 32'd3, 32'd4, 64'd12, 1'b0, NLAT, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Shares one multiplier_iterative instance between NUM_REQ requesters. Each requester issues an operand pair with a valid/ready handshake. The block grants requesters in round-robin order, sequences the multiplier's valid_in/valid_out protocol, and returns the 64-bit product to the granted requester with a valid/ready handshake. A watchdog flags a multiplier that never completes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDW, 2, grant id width, equal to clog2(NUM_REQ)
TIMEOUT_CYCLES, 64, maximum WAIT cycles before the op is aborted with an error

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*32  flattened operand A; requester i occupies bits [32i+31:32i]
req_b  in  NUM_REQ*32  flattened operand B, same packing
rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_r  out  64  product; valid only while some rsp_valid bit is high
rsp_err  out  1  high with rsp_valid when the op timed out; rsp_r is 0 in that case
busy  out  1  high in any state except IDLE
grant_id  out  IDW  index of the current owner; holds its last value in IDLE
mul_valid_in  out  1  single-cycle start pulse to the multiplier
mul_a  out  32  operand A to the multiplier, held from LAUNCH through WAIT
mul_b  out  32  operand B to the multiplier, held from LAUNCH through WAIT
mul_valid_out  in  1  multiplier result valid; may remain high until the next start
mul_r  in  64  multiplier product

Behaviour:
- Reset (reset_n sampled low at a clock edge), all outputs and state:
  - state=IDLE, rr_ptr=0, grant_id=0
  - req_ready=0, rsp_valid=0, rsp_err=0, rsp_r=0
  - mul_valid_in=0, mul_a=0, mul_b=0, busy=0
  - Reset during any state aborts the in-flight op with no response. A multiplier result arriving after reset is ignored, because the state is IDLE.
- FSM states: IDLE, LAUNCH, WAIT, DELIVER.
- IDLE:
  - Combinational round-robin pick among req_valid, highest priority at rr_ptr, searching upward with wrap.
  - req_ready[winner]=1 in the same cycle.
  - On that edge: latch operands into mul_a/mul_b, set grant_id=winner, go to LAUNCH.
  - With no req_valid, stay in IDLE.
  - req_ready is never high outside IDLE.
- LAUNCH:
  - mul_valid_in=1 for exactly this cycle.
  - Clear the WAIT counter; go to WAIT.
- WAIT:
  - mul_valid_in=0. mul_valid_out is considered only from the first WAIT cycle onward, so a level left high from the previous op in the LAUNCH cycle is ignored.
  - On mul_valid_out=1: capture rsp_r=mul_r, set rsp_err=0, go to DELIVER.
  - Counter reaching TIMEOUT_CYCLES-1 without completion: set rsp_r=0, rsp_err=1, go to DELIVER.
  - Completion wins if it coincides with the timeout.
- DELIVER:
  - rsp_valid[grant_id]=1; rsp_r and rsp_err are held stable.
  - On rsp_ready[grant_id]=1: set rr_ptr=(grant_id+1) mod NUM_REQ, go to IDLE. rsp_valid drops on the following cycle.
  - rsp_ready bits of non-owners are ignored.
  - No new request is accepted in the same cycle as the response handshake.
- Latency:
  - Minimum request-accept to rsp_valid = 2 + multiplier latency cycles.
  - Minimum issue rate: one op per (4 + multiplier latency) cycles.
- Fairness: every requester holding req_valid is granted within NUM_REQ grants.
- Requesters must hold req_a/req_b stable while req_valid is high and not yet accepted.
- Arithmetic: unsigned 32x32 to 64; no modification of mul_r.

Decomposition:
- Package mul_arb_pkg holds:
  - state_t enum (IDLE, LAUNCH, WAIT, DELIVER)
  - constants OPW=32 and RW=64
  - a function for clog2
- One sub-module, rr_arbiter (NUM_REQ):
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
  - Pointer update stays in mul_arbiter.

Test Plan:
- Single request: requester 1 sends a=7, b=9 → req_ready[1] pulses once, mul_valid_in pulses one cycle later, rsp_valid[1] with rsp_r=63 and rsp_err=0; rsp_ready held high returns the block to IDLE.
- Contention: all four requesters valid from reset with a=i+1, b=1000 → grants in order 0,1,2,3 with products 1000, 2000, 3000, 4000; a second round with rr_ptr=0 repeats the order.
- Round-robin pointer: after requester 2 is served, requesters 0 and 3 are valid → requester 3 is granted before requester 0.
- Back-pressure and edge values: rsp_ready held low for 10 cycles, a=32'hFFFFFFFF, b=32'hFFFFFFFF → rsp_r=64'hFFFFFFFE00000001 stable throughout and no new req_ready; 100 random pairs match a*b.
- Timeout and stale valid: multiplier model holds mul_valid_out=1 from the prior op and never completes the new one → stale level ignored during LAUNCH, rsp_err=1 and rsp_r=0 after TIMEOUT_CYCLES WAIT cycles.
- Reset mid-op: reset_n low for one cycle during WAIT → next cycle state is IDLE with busy=0 and rsp_valid=0; a late mul_valid_out produces no response.
